// File: rtl/layer00_pass_sched.sv
// ---------------------------------------------------------------------------
// layer00_pass_sched
//   Sequences layer 0 over NUM_PASS output-filter groups (4 filters per pass).
//   Holds the 32 x 16-bit per-filter bias table, presents the 4 biases of the
//   current pass, pulses the layer start for each pass, counts output valids,
//   drains the pipeline between passes and reports frame done / overflow.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   i_start             frame start request (single-cycle pulse)
//   i_abort             abort the current frame
//   i_bias_we/addr/data bias table write port (idle only, addr = 4*pass+filter)
//   i_out_vld           output valid from the activation stage
//   o_layer_start       one-cycle start pulse per pass
//   o_bias0..o_bias3    biases of the current pass
//   o_pass              current pass index
//   o_pix_cnt           valids counted in the current pass
//   o_busy              high from START through DRAIN
//   o_done              one-cycle frame completion pulse
//   o_ovf               sticky: valid seen in START/DRAIN
// ---------------------------------------------------------------------------
module layer00_pass_sched #(
  parameter int unsigned NUM_PASS     = 4,
  parameter int unsigned PIX_PER_PASS = 16384,
  parameter int unsigned DRAIN_CYC    = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic        i_abort,
  input  logic        i_bias_we,
  input  logic [4:0]  i_bias_addr,
  input  logic [15:0] i_bias_data,
  input  logic        i_out_vld,
  output logic        o_layer_start,
  output logic [15:0] o_bias0,
  output logic [15:0] o_bias1,
  output logic [15:0] o_bias2,
  output logic [15:0] o_bias3,
  output logic [2:0]  o_pass,
  output logic [15:0] o_pix_cnt,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_ovf
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  localparam logic [15:0] PIX_LAST   = 16'(PIX_PER_PASS - 1);
  localparam logic [7:0]  DRAIN_LAST = 8'(DRAIN_CYC - 1);
  localparam logic [2:0]  LAST_PASS  = 3'(NUM_PASS - 1);
  localparam logic [5:0]  TBL_DEPTH  = 6'(4 * NUM_PASS);

  state_t      state_q, state_d;
  logic [2:0]  pass_q, pass_d;
  logic [15:0] pix_q, pix_d;
  logic [7:0]  drain_q, drain_d;
  logic        ovf_q, ovf_d;
  logic        ls_q, ls_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] bias_q [4];
  logic [15:0] bias_d [4];
  logic        load_bias;

  // Bias table: deliberately not reset.
  logic [15:0] table_q [32];

  always_ff @(posedge clk) begin
    if (i_bias_we && !busy_q && ({1'b0, i_bias_addr} < TBL_DEPTH)) begin
      table_q[i_bias_addr] <= i_bias_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    pass_d    = pass_q;
    pix_d     = pix_q;
    drain_d   = drain_q;
    ovf_d     = ovf_q;
    load_bias = 1'b0;

    case (state_q)
      S_IDLE: begin
        // Abort wins over a simultaneous start.
        if (!i_abort && i_start) begin
          state_d   = S_START;
          pass_d    = '0;
          pix_d     = '0;
          ovf_d     = 1'b0;
          load_bias = 1'b1;
        end
      end
      S_START: begin
        if (i_abort) begin
          state_d = S_IDLE;
        end else begin
          if (i_out_vld) ovf_d = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (i_abort) begin
          state_d = S_IDLE;
        end else if (i_out_vld) begin
          pix_d = pix_q + 16'd1;
          if (pix_q == PIX_LAST) begin
            state_d = S_DRAIN;
            drain_d = '0;
          end
        end
      end
      S_DRAIN: begin
        if (i_abort) begin
          state_d = S_IDLE;
        end else begin
          if (i_out_vld) ovf_d = 1'b1;
          if (drain_q == DRAIN_LAST) begin
            if (pass_q < LAST_PASS) begin
              state_d   = S_START;
              pass_d    = pass_q + 3'd1;
              pix_d     = '0;
              load_bias = 1'b1;
            end else begin
              state_d = S_DONE;
            end
          end else begin
            drain_d = drain_q + 8'd1;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state so they line up with it.
    ls_d   = (state_d == S_START);
    busy_d = (state_d == S_START) || (state_d == S_RUN) || (state_d == S_DRAIN);
    done_d = (state_d == S_DONE);

    for (int unsigned k = 0; k < 4; k++) begin
      bias_d[k] = load_bias ? table_q[{pass_d, 2'(k)}] : bias_q[k];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pass_q  <= '0;
      pix_q   <= '0;
      drain_q <= '0;
      ovf_q   <= 1'b0;
      ls_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int unsigned k = 0; k < 4; k++) begin
        bias_q[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      pass_q  <= pass_d;
      pix_q   <= pix_d;
      drain_q <= drain_d;
      ovf_q   <= ovf_d;
      ls_q    <= ls_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      for (int unsigned k = 0; k < 4; k++) begin
        bias_q[k] <= bias_d[k];
      end
    end
  end

  assign o_layer_start = ls_q;
  assign o_bias0       = bias_q[0];
  assign o_bias1       = bias_q[1];
  assign o_bias2       = bias_q[2];
  assign o_bias3       = bias_q[3];
  assign o_pass        = pass_q;
  assign o_pix_cnt     = pix_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_ovf         = ovf_q;

endmodule

// File: tb/tb_layer00_pass_sched.sv
// ---------------------------------------------------------------------------
// tb_layer00_pass_sched
//   Two instances share the stimulus: u_dut0 (NUM_PASS=2, PIX_PER_PASS=4,
//   DRAIN_CYC=3) and u_dut1 (NUM_PASS=1, PIX_PER_PASS=1, DRAIN_CYC=3).
//   A frame-level reference model predicts every output of both each cycle.
// ---------------------------------------------------------------------------
module tb_layer00_pass_sched;

  logic        clk;
  logic        rst;
  logic        i_start, i_abort, i_bias_we, i_out_vld;
  logic [4:0]  i_bias_addr;
  logic [15:0] i_bias_data;

  logic        ls [2];
  logic        busy [2];
  logic        done [2];
  logic        ovf [2];
  logic [15:0] b0 [2];
  logic [15:0] b1 [2];
  logic [15:0] b2 [2];
  logic [15:0] b3 [2];
  logic [15:0] pix [2];
  logic [2:0]  pass [2];

  int vectors = 0;
  int miscompares = 0;

  layer00_pass_sched #(.NUM_PASS(2), .PIX_PER_PASS(4), .DRAIN_CYC(3)) u_dut0 (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
    .i_bias_we(i_bias_we), .i_bias_addr(i_bias_addr), .i_bias_data(i_bias_data),
    .i_out_vld(i_out_vld), .o_layer_start(ls[0]),
    .o_bias0(b0[0]), .o_bias1(b1[0]), .o_bias2(b2[0]), .o_bias3(b3[0]),
    .o_pass(pass[0]), .o_pix_cnt(pix[0]), .o_busy(busy[0]),
    .o_done(done[0]), .o_ovf(ovf[0])
  );

  layer00_pass_sched #(.NUM_PASS(1), .PIX_PER_PASS(1), .DRAIN_CYC(3)) u_dut1 (
    .clk(clk), .rst(rst), .i_start(i_start), .i_abort(i_abort),
    .i_bias_we(i_bias_we), .i_bias_addr(i_bias_addr), .i_bias_data(i_bias_data),
    .i_out_vld(i_out_vld), .o_layer_start(ls[1]),
    .o_bias0(b0[1]), .o_bias1(b1[1]), .o_bias2(b2[1]), .o_bias3(b3[1]),
    .o_pass(pass[1]), .o_pix_cnt(pix[1]), .o_busy(busy[1]),
    .o_done(done[1]), .o_ovf(ovf[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: phase 0=idle 1=start 2=run 3=drain 4=done
  int          NP [2] = '{2, 1};
  int          PX [2] = '{4, 1};
  int          DC [2] = '{3, 3};
  int          m_ph [2];
  int          m_pass [2];
  int          m_pix [2];
  int          m_wait [2];
  logic        m_ovf [2];
  logic [15:0] m_bias [2][4];
  logic [15:0] m_tab [2][32];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_ph[k] = 0; m_pass[k] = 0; m_pix[k] = 0; m_wait[k] = 0; m_ovf[k] = 1'b0;
      for (int j = 0; j < 4; j++) m_bias[k][j] = 16'h0000;
    end
  endtask

  task automatic model_load(input int k);
    for (int j = 0; j < 4; j++) m_bias[k][j] = m_tab[k][4 * m_pass[k] + j];
  endtask

  task automatic model_edge(input int k, input logic s, input logic a, input logic v,
                            input logic we, input logic [4:0] ad, input logic [15:0] d);
    bit was_busy;
    was_busy = (m_ph[k] >= 1 && m_ph[k] <= 3);
    case (m_ph[k])
      0: if (!a && s) begin
           m_ph[k] = 1; m_pass[k] = 0; m_pix[k] = 0; m_ovf[k] = 1'b0; model_load(k);
         end
      1: if (a) m_ph[k] = 0;
         else begin
           if (v) m_ovf[k] = 1'b1;
           m_ph[k] = 2;
         end
      2: if (a) m_ph[k] = 0;
         else if (v) begin
           m_pix[k]++;
           if (m_pix[k] == PX[k]) begin m_ph[k] = 3; m_wait[k] = DC[k]; end
         end
      3: if (a) m_ph[k] = 0;
         else begin
           if (v) m_ovf[k] = 1'b1;
           m_wait[k]--;
           if (m_wait[k] == 0) begin
             if (m_pass[k] + 1 < NP[k]) begin
               m_ph[k] = 1; m_pass[k]++; m_pix[k] = 0; model_load(k);
             end else begin
               m_ph[k] = 4;
             end
           end
         end
      default: m_ph[k] = 0;
    endcase
    if (we && !was_busy && int'(ad) < 4 * NP[k]) m_tab[k][ad] = d;
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("layer_start%0d", k), 32'(ls[k]),   32'(m_ph[k] == 1));
      chk($sformatf("busy%0d", k),        32'(busy[k]), 32'(m_ph[k] >= 1 && m_ph[k] <= 3));
      chk($sformatf("done%0d", k),        32'(done[k]), 32'(m_ph[k] == 4));
      chk($sformatf("ovf%0d", k),         32'(ovf[k]),  32'(m_ovf[k]));
      chk($sformatf("pass%0d", k),        32'(pass[k]), 32'(m_pass[k]));
      chk($sformatf("pix%0d", k),         32'(pix[k]),  32'(m_pix[k]));
      chk($sformatf("bias0_%0d", k),      32'(b0[k]),   32'(m_bias[k][0]));
      chk($sformatf("bias1_%0d", k),      32'(b1[k]),   32'(m_bias[k][1]));
      chk($sformatf("bias2_%0d", k),      32'(b2[k]),   32'(m_bias[k][2]));
      chk($sformatf("bias3_%0d", k),      32'(b3[k]),   32'(m_bias[k][3]));
    end
  endtask

  // One clock: inputs held across the edge, model advanced, outputs checked.
  task automatic cyc(input logic s, input logic a, input logic v,
                     input logic we = 1'b0, input logic [4:0] ad = 5'd0,
                     input logic [15:0] d = 16'h0000);
    i_start = s; i_abort = a; i_out_vld = v;
    i_bias_we = we; i_bias_addr = ad; i_bias_data = d;
    @(posedge clk);
    for (int k = 0; k < 2; k++) model_edge(k, s, a, v, we, ad, d);
    #1;
    check_all();
    i_start = 1'b0; i_abort = 1'b0; i_out_vld = 1'b0; i_bias_we = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_all();
  endtask

  initial begin
    rst = 1'b0; i_start = 1'b0; i_abort = 1'b0; i_out_vld = 1'b0;
    i_bias_we = 1'b0; i_bias_addr = 5'd0; i_bias_data = 16'h0000;
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 32; j++) m_tab[k][j] = 16'hxxxx;

    @(posedge clk);
    #1;
    do_reset();
    chk("reset_busy", 32'(busy[0]), 32'd0);
    chk("reset_pix", 32'(pix[0]), 32'd0);

    // Bias load while idle
    for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 5'(i), 16'h0010 + 16'(i));

    // Pass 0 start
    cyc(1'b1, 1'b0, 1'b0);
    chk("tp_ls_p0", 32'(ls[0]), 32'd1);
    chk("tp_bias0_p0", 32'(b0[0]), 32'h0010);
    chk("tp_bias3_p0", 32'(b3[0]), 32'h0013);
    cyc(1'b0, 1'b0, 1'b0);
    // Consecutive valids; busy-time bias write and start must be ignored
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 16'hFFFF);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    chk("tp_pix_full", 32'(pix[0]), 32'd4);
    // Overflow valid in drain
    cyc(1'b0, 1'b0, 1'b1);
    chk("tp_ovf_set", 32'(ovf[0]), 32'd1);
    chk("tp_pix_hold", 32'(pix[0]), 32'd4);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("tp_ls_p1", 32'(ls[0]), 32'd1);
    chk("tp_pass_p1", 32'(pass[0]), 32'd1);
    chk("tp_bias0_p1", 32'(b0[0]), 32'h0014);
    chk("tp_bias3_p1", 32'(b3[0]), 32'h0017);
    // Pass 1 with gapped valids
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("tp_done", 32'(done[0]), 32'd1);
    chk("tp_done_busy", 32'(busy[0]), 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("tp_done_pulse", 32'(done[0]), 32'd0);
    chk("tp_pix_after_done", 32'(pix[0]), 32'd4);

    // New start clears ovf; abort after 2 valids in pass 1
    cyc(1'b1, 1'b0, 1'b0);
    chk("tp_ovf_clr", 32'(ovf[0]), 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0);
    chk("tp_abort_busy", 32'(busy[0]), 32'd0);
    chk("tp_abort_pix", 32'(pix[0]), 32'd2);
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    chk("tp_abort_wins", 32'(busy[0]), 32'd0);
    cyc(1'b1, 1'b0, 1'b0);
    chk("tp_restart_pass", 32'(pass[0]), 32'd0);
    chk("tp_restart_ls", 32'(ls[0]), 32'd1);

    // Asynchronous reset during drain
    cyc(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    do_reset();
    chk("tp_rst_pix", 32'(pix[0]), 32'd0);
    chk("tp_rst_bias", 32'(b0[0]), 32'd0);

    // Single-pass, single-valid instance
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("tp_short_not_yet", 32'(done[1]), 32'd0);
    cyc(1'b0, 1'b0, 1'b0);
    chk("tp_short_done", 32'(done[1]), 32'd1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        cyc(($urandom_range(0, 15) == 0), ($urandom_range(0, 63) == 0),
            1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
            5'($urandom_range(0, 31)), 16'($urandom));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/layer00_pass_sched.md
Name: layer00_pass_sched

Overview:
- Sequences layer 0 over its output-filter groups. The layer datapath computes 4 filters per pass; this block runs NUM_PASS passes per frame.
- Holds the per-filter bias table and presents the 4 biases for the current pass to the adder trees.
- Issues the one-cycle layer start pulse for each pass.
- Counts post-activation output valids, drains the pipeline between passes, and reports frame completion and overflow.

Parameters:
- NUM_PASS, 4, filter groups per frame (4 filters each). Range 1..8.
- PIX_PER_PASS, 16384, output valids expected per pass. Range 1..65535.
- DRAIN_CYC, 8, idle cycles to wait after the last expected valid before the next pass starts. Range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous reset, active-high
- i_start  in  1  frame start request, single-cycle pulse
- i_abort  in  1  abort the current frame
- i_bias_we  in  1  bias table write enable
- i_bias_addr  in  5  bias index, 4*pass+filter
- i_bias_data  in  16  bias value
- i_out_vld  in  1  output valid from the activation stage (filter-0 lane)
- o_layer_start  out  1  one-cycle start pulse to the layer datapath
- o_bias0..o_bias3  out  16 each  biases for the current pass
- o_pass  out  3  current pass index
- o_pix_cnt  out  16  valids counted in the current pass
- o_busy  out  1  high from START through DRAIN
- o_done  out  1  one-cycle pulse when the frame completes
- o_ovf  out  1  sticky flag: i_out_vld seen outside RUN while busy

Behaviour:
- Reset values: all outputs 0; state IDLE; bias table contents undefined (the table is not reset).
- Bias table: 32 x 16-bit.
  - Write occurs when i_bias_we=1 and o_busy=0.
  - Writes while busy are ignored.
  - Addresses >= 4*NUM_PASS are ignored.
- o_biasK is registered. It loads table[4*pass+K] on entry to START and is held stable through RUN and DRAIN.
- FSM states: IDLE, START, RUN, DRAIN, DONE.
  - IDLE: when i_start=1, go to START. This sets pass=0, pix_cnt=0 and clears o_ovf.
  - START: lasts 1 cycle. o_layer_start=1, o_busy=1. Go to RUN.
  - RUN: each i_out_vld increments pix_cnt. A valid with pix_cnt==PIX_PER_PASS-1 moves to DRAIN and zeroes the drain counter.
  - DRAIN: the drain counter increments every cycle. When it reaches DRAIN_CYC-1, go to START with pass+1 and pix_cnt=0 if pass<NUM_PASS-1; otherwise go to DONE.
  - DONE: lasts 1 cycle. o_done=1, o_busy=0. Go to IDLE.
- Latency: i_start sampled at edge n → o_layer_start and o_busy high at n+1. The last pass's DRAIN exit → o_done high for exactly 1 cycle.
- o_pix_cnt shows the count of the current pass. It holds its final value through DRAIN and resets to 0 on entry to each START. It is never cleared in IDLE, so it holds its last value after DONE.
- o_ovf: set in START or DRAIN when i_out_vld=1. Such valids are not counted. The flag stays set until the next accepted i_start.
- Valids in IDLE or DONE are ignored and do not set o_ovf.
- i_start while busy or in DONE is ignored.
- i_abort: takes priority over all transitions. In any busy state it forces IDLE on the next edge, with o_busy=0, no o_done and no o_layer_start. Pass and pix_cnt keep their values.
- i_abort and i_start together in IDLE: abort wins and the start is dropped.
- rst mid-frame: all outputs return to reset values immediately (asynchronous).
- Widths:
  - pix_cnt is 16-bit. It cannot wrap because RUN exits at PIX_PER_PASS.
  - The drain counter is 8-bit.
  - pass is 3-bit.

Test Plan (NUM_PASS=2, PIX_PER_PASS=4, DRAIN_CYC=3 unless noted):
- Bias load: write table[0..7]=0x0010..0x0017 while idle, then i_start → at o_layer_start, o_bias0..3=0x0010..0x0013. At the second o_layer_start, o_bias0..3=0x0014..0x0017 and o_pass=1.
- Full frame: i_start, then 4 i_out_vld per pass (consecutive and gapped) → o_layer_start twice, 3 DRAIN cycles between passes, o_done one cycle after the second DRAIN, o_busy low with it, o_ovf=0.
- Overflow: drive a 5th i_out_vld during DRAIN of pass 0 → o_ovf=1, o_pix_cnt stays 4, frame still completes. The next i_start clears o_ovf.
- Busy protection: bias write of 0xFFFF to addr 4 and a second i_start during pass-0 RUN → pass 1 o_bias0 is still 0x0014 and no extra o_layer_start occurs.
- Abort: i_abort after 2 valids in pass 1 → IDLE next cycle, o_done never pulses, o_pix_cnt=2. A following i_start restarts at pass 0.
- Reset: assert rst during DRAIN → all outputs 0 immediately. After deassert, i_start with PIX_PER_PASS=1 and NUM_PASS=1 gives o_done after 1 valid plus DRAIN_CYC cycles.
